// File: rtl/fifo_frame_tx.sv
// FIFO read-side drain: bypassing 2-entry skid buffer feeding a framed valid/ready stream.
// Optional trailing checksum word is enabled with `define FIFO_FRAME_TX_CSUM_EN.
module fifo_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  localparam int IDXW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
`ifdef FIFO_FRAME_TX_CSUM_EN
  localparam logic [1:0] ST_CSUM = 2'd2;
`endif

  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] skid_mem_q [2];
  logic                  skid_wp_q, skid_rp_q;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_sop_q, m_sop_d;
  logic                  m_eop_q, m_eop_d;
  logic [CNT_WIDTH-1:0]  frames_q, frames_d;
`ifdef FIFO_FRAME_TX_CSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  load_csum;
`endif

  logic                  skid_has, skid_avail, out_free, load_word;
  logic                  skid_push, skid_pop, rd_eff;
  logic [DATA_WIDTH-1:0] skid_head;

  // An empty skid buffer passes the arriving FIFO word straight through, which
  // keeps occupancy at zero and sustains one word per cycle under the issue rule.
  assign skid_has   = (skid_cnt_q != 2'd0);
  assign skid_avail = skid_has | inflight_q;
  assign skid_head  = skid_has ? skid_mem_q[skid_rp_q] : fifo_data;
  assign out_free   = ~m_valid_q | m_ready;
`ifdef FIFO_FRAME_TX_CSUM_EN
  assign load_word  = out_free & skid_avail & (state_q != ST_CSUM);
  assign load_csum  = out_free & (state_q == ST_CSUM);
`else
  assign load_word  = out_free & skid_avail;
`endif
  assign skid_pop   = load_word & skid_has;
  assign skid_push  = inflight_q & ~(load_word & ~skid_has);

  assign fifo_rd = ~fifo_empty & ((skid_cnt_q + {1'b0, inflight_q}) < 2'd2);
  assign rd_eff  = fifo_rd & ~fifo_empty;

  always_comb begin
    skid_cnt_d = skid_cnt_q;
    if (skid_push & ~skid_pop)      skid_cnt_d = skid_cnt_q + 2'd1;
    else if (~skid_push & skid_pop) skid_cnt_d = skid_cnt_q - 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sop_d   = m_sop_q;
    m_eop_d   = m_eop_q;
    frames_d  = frames_q;
`ifdef FIFO_FRAME_TX_CSUM_EN
    acc_d     = acc_q;
`endif
    if (m_valid_q & m_ready & m_eop_q) frames_d = frames_q + CNT_WIDTH'(1);
    if (out_free) m_valid_d = 1'b0;

    if (load_word) begin
      m_valid_d = 1'b1;
      m_data_d  = skid_head;
      m_sop_d   = (state_q == ST_IDLE);
      m_eop_d   = 1'b0;
`ifdef FIFO_FRAME_TX_CSUM_EN
      acc_d     = (state_q == ST_IDLE) ? skid_head : acc_q + skid_head;
`endif
      if (state_q == ST_IDLE) begin
        state_d = ST_DATA;
        idx_d   = IDXW'(1);
      end else if (idx_q == LAST_IDX) begin
        idx_d = '0;
`ifdef FIFO_FRAME_TX_CSUM_EN
        state_d = ST_CSUM;
`else
        m_eop_d = 1'b1;
        state_d = ST_IDLE;
`endif
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
`ifdef FIFO_FRAME_TX_CSUM_EN
    else if (load_csum) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_q;
      m_sop_d   = 1'b0;
      m_eop_d   = 1'b1;
      state_d   = ST_IDLE;
    end
`endif
  end

  // Skid storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (skid_push) skid_mem_q[skid_wp_q] <= fifo_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      skid_wp_q  <= 1'b0;
      skid_rp_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_sop_q    <= 1'b0;
      m_eop_q    <= 1'b0;
      frames_q   <= '0;
`ifdef FIFO_FRAME_TX_CSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      inflight_q <= rd_eff;
      if (skid_push) skid_wp_q <= ~skid_wp_q;
      if (skid_pop)  skid_rp_q <= ~skid_rp_q;
      skid_cnt_q <= skid_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_sop_q    <= m_sop_d;
      m_eop_q    <= m_eop_d;
      frames_q   <= frames_d;
`ifdef FIFO_FRAME_TX_CSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_sop       = m_sop_q;
  assign m_eop       = m_eop_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_frame_tx.sv
// Scoreboard bench for fifo_frame_tx: behavioural upstream FIFO, frame model, decoupled monitor.
`timescale 1ns/1ps
module tb_fifo_frame_tx;
  localparam int DW = 8;
  localparam int FL = 4;
  localparam int CW = 4;
`ifdef FIFO_FRAME_TX_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_sop;
  logic          m_eop;
  logic [CW-1:0] frames_sent;

  fifo_frame_tx #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Upstream FIFO model with a one-cycle registered read.
  logic [DW-1:0] fq [$];
  int n_push = 0;
  int n_pop  = 0;
  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    if (!rst && fifo_rd && (n_push != n_pop)) begin
      fifo_data <= fq.pop_front();
      n_pop     <= n_pop + 1;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } exp_t;
  exp_t exq [$];
  int widx = 0;
  logic [DW-1:0] msum = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Frame model: word position within a frame decides sop/eop; checksum is a plain sum.
  task automatic push_word(input logic [DW-1:0] w);
    exp_t e;
    fq.push_back(w);
    n_push++;
    e.d   = w;
    e.sop = (widx == 0);
    e.eop = (!CSUM && widx == FL - 1);
    exq.push_back(e);
    msum = (widx == 0) ? w : DW'(msum + w);
    widx++;
    if (widx == FL) begin
      widx = 0;
      if (CSUM) begin
        e.d = msum; e.sop = 1'b0; e.eop = 1'b1;
        exq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exq.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_left", exq.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_sop"}, m_sop, 0);
    chk({tag, "_m_eop"}, m_eop, 0);
    chk({tag, "_frames"}, frames_sent, 0);
  endtask

  // m_ready driver: 0 = always 1, 1 = alternate, 2 = random, 3 = held low.
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability and the counter.
  int n_xfer = 0;
  int exp_frames = 0;
  bit pend_fr = 0;
  bit stall = 0;
  logic [DW+1:0] held = '0;
  exp_t got;

  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
      pend_fr = 0;
      exp_frames = 0;
    end else begin
      if (pend_fr) begin
        chk("frames_sent", frames_sent, exp_frames[CW-1:0]);
        pend_fr = 0;
      end
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", {m_data, m_sop, m_eop}, held);
      end
      if (fifo_rd) chk("rd_when_empty", fifo_empty, 0);
      if (m_valid && m_ready) begin
        if (exq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          got = exq.pop_front();
          chk("m_data", m_data, got.d);
          chk("m_sop", m_sop, got.sop);
          chk("m_eop", m_eop, got.eop);
          $display("xfer %0d data=%02h sop=%0d eop=%0d frames=%0d", n_xfer, m_data, m_sop, m_eop, frames_sent);
          n_xfer++;
          if (got.eop) begin
            exp_frames++;
            pend_fr = 1;
          end
        end
      end
      stall = m_valid && !m_ready;
      held  = {m_data, m_sop, m_eop};
    end
  end

  initial begin
    int base;
    int k;
    rmode = 0;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // Basic frame, with first-word latency check.
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    @(negedge clk);
    chk("lat_rd", fifo_rd, 1);
    @(negedge clk);
    chk("lat_n1_valid", m_valid, 0);
    @(negedge clk);
    chk("lat_n2_valid", m_valid, 1);
    drain(200);
    chk("basic_frames", frames_sent, 1);

    // Checksum wraps to zero.
    push_word(8'hFF); push_word(8'hFF); push_word(8'hFF); push_word(8'h03);
    drain(200);

    // Backpressure, alternating ready.
    rmode = 1;
    for (int i = 0; i < 12; i++) push_word(DW'(8'h10 + i));
    drain(500);

    // Empty gap mid-frame.
    rmode = 0;
    tick();
    push_word(8'h21); push_word(8'h22);
    drain(200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gap_valid", m_valid, 0);
    end
    tick();
    push_word(8'h23); push_word(8'h24);
    drain(200);

    // Random traffic, wraps the 4-bit frame counter.
    rmode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_word(DW'($urandom));
    end
    drain(3000);

    // Reset mid-frame after two transfers.
    rmode = 0;
    tick();
    base = n_xfer;
    for (int i = 0; i < 4; i++) push_word(DW'(8'h40 + i));
    k = 0;
    while (n_xfer < base + 2 && k < 100) begin
      tick();
      k++;
    end
    chk("mid_xfers", n_xfer - base, 2);
    rmode = 3;
    rst = 1'b1;
    exq.delete();
    fq.delete();
    n_push = n_pop;
    widx = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rmode = 0;
    tick();
    for (int i = 0; i < 4; i++) push_word(DW'(8'h50 + i));
    drain(200);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
